// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module  : serial_subtractor_pkg
// Brief   : Shared types for the bit-serial subtractor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// ============================================================================
// Module  : full_subtractor
// Brief   : Combinational 1-bit full-subtractor cell (d = a - b - bin).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic BIN,
  output logic D,
  output logic BOUT
);

  assign D    = A ^ B ^ BIN;
  assign BOUT = (~A & B) | (~(A ^ B) & BIN);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module  : serial_subtractor
// Brief   : LSB-first bit-serial WIDTH-bit subtractor behind a start/done handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BOUT
);
  import serial_subtractor_pkg::*;

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sha_q, sha_d;
  logic [WIDTH-1:0]   shb_q, shb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               borrow_q, borrow_d;
  logic               bout_q, bout_d;
  logic               cell_d, cell_bout;

  full_subtractor u_cell (
    .A    (sha_q[0]),
    .B    (shb_q[0]),
    .BIN  (borrow_q),
    .D    (cell_d),
    .BOUT (cell_bout)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      sha_q    <= '0;
      shb_q    <= '0;
      res_q    <= '0;
      dout_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sha_q    <= sha_d;
      shb_q    <= shb_d;
      res_q    <= res_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sha_d    = sha_q;
    shb_d    = shb_q;
    res_d    = res_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d  = ST_RUN;
          sha_d    = A;
          shb_d    = B;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      ST_RUN: begin
        sha_d    = sha_q >> 1;
        shb_d    = shb_q >> 1;
        res_d    = {cell_d, res_q[WIDTH-1:1]};
        borrow_d = cell_bout;
        cnt_d    = cnt_q + CW'(1);
        // Publish the result together with the final bit so D/BOUT hold until the next FIN.
        if (cnt_q == LAST) begin
          state_d = ST_FIN;
          cnt_d   = '0;
          dout_d  = {cell_d, res_q[WIDTH-1:1]};
          bout_d  = cell_bout;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign BUSY = (state_q == ST_RUN);
  assign DONE = (state_q == ST_FIN);
  assign D    = dout_q;
  assign BOUT = bout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module  : tb_serial_subtractor
// Brief   : Self-checking bench for serial_subtractor at WIDTH=4 and WIDTH=8.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       START4 = 1'b0, START8 = 1'b0;
  logic [3:0] A4 = '0, B4 = '0, D4;
  logic [7:0] A8 = '0, B8 = '0, D8;
  logic       BUSY4, DONE4, BOUT4, BUSY8, DONE8, BOUT8;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .CLK(CLK), .RST(RST), .START(START4), .A(A4), .B(B4),
    .BUSY(BUSY4), .DONE(DONE4), .D(D4), .BOUT(BOUT4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .START(START8), .A(A8), .B(B8),
    .BUSY(BUSY8), .DONE(DONE8), .D(D8), .BOUT(BOUT8)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Start one WIDTH=4 op, scramble the operands after capture, wait for DONE.
  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     output logic [3:0] d, output logic bo, output int lat, output bit to);
    A4 = a; B4 = b; START4 = 1'b1;
    tick;
    START4 = 1'b0; A4 = ~a; B4 = ~b;
    to = 1'b1; lat = 0; d = '0; bo = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (DONE4) begin
        to = 1'b0; lat = i; d = D4; bo = BOUT4;
        break;
      end
    end
    tick;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     output logic [7:0] d, output logic bo, output int lat, output bit to);
    A8 = a; B8 = b; START8 = 1'b1;
    tick;
    START8 = 1'b0; A8 = ~a; B8 = ~b;
    to = 1'b1; lat = 0; d = '0; bo = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick;
      if (DONE8) begin
        to = 1'b0; lat = i; d = D8; bo = BOUT8;
        break;
      end
    end
    tick;
  endtask

  task automatic wait_done8(output int n, output bit to);
    to = 1'b1; n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (DONE8) begin
        to = 1'b0; n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; START4 = 1'b1; START8 = 1'b1;
    tick; tick;
    checks++;
    if ({BUSY4, DONE4, D4, BOUT4} !== 7'b0) begin
      errors++;
      $display("FAIL reset4: busy=%b done=%b d=%h bout=%b, required all 0", BUSY4, DONE4, D4, BOUT4);
    end
    checks++;
    if ({BUSY8, DONE8, D8, BOUT8} !== 11'b0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b d=%h bout=%b, required all 0", BUSY8, DONE8, D8, BOUT8);
    end
    RST = 1'b0; START4 = 1'b0; START8 = 1'b0;
    tick;
  endtask

  task automatic test_basic_timing;
    int busy_cnt;
    busy_cnt = 0;
    A4 = 4'd5; B4 = 4'd3; START4 = 1'b1;
    tick;
    START4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (BUSY4 && !DONE4) busy_cnt++;
      tick;
    end
    checks++;
    if (busy_cnt != 4) begin
      errors++;
      $display("FAIL busy_len: busy cycles=%0d, required 4", busy_cnt);
    end
    checks++;
    if (DONE4 !== 1'b1 || BUSY4 !== 1'b0 || D4 !== 4'd2 || BOUT4 !== 1'b0) begin
      errors++;
      $display("FAIL op_5_3: done=%b busy=%b d=%0d bout=%b, required done=1 busy=0 d=2 bout=0",
               DONE4, BUSY4, D4, BOUT4);
    end
    tick;
    checks++;
    if (DONE4 !== 1'b0 || D4 !== 4'd2) begin
      errors++;
      $display("FAIL done_pulse: done=%b d=%0d, required done=0 d=2 (held)", DONE4, D4);
    end
  endtask

  task automatic test_corner_values;
    logic [3:0] a_t[3], b_t[3], d;
    logic bo;
    int lat;
    bit to;
    a_t = '{4'd3, 4'd0, 4'd15};
    b_t = '{4'd5, 4'd1, 4'd15};
    for (int i = 0; i < 3; i++) begin
      op4(a_t[i], b_t[i], d, bo, lat, to);
      checks++;
      if (to || lat != 4 || d !== 4'(a_t[i] - b_t[i]) || bo !== (a_t[i] < b_t[i])) begin
        errors++;
        $display("FAIL corner %0d-%0d: to=%b lat=%0d d=%h bout=%b, required lat=4 d=%h bout=%b",
                 a_t[i], b_t[i], to, lat, d, bo, 4'(a_t[i] - b_t[i]), (a_t[i] < b_t[i]));
      end
    end
  endtask

  task automatic test_start_while_busy;
    int dones;
    bit busy_gap;
    dones = 0; busy_gap = 1'b0;
    A4 = 4'd7; B4 = 4'd2; START4 = 1'b1;
    tick;
    A4 = 4'd9;
    for (int i = 0; i < 12; i++) begin
      if (i < 4 && !BUSY4) busy_gap = 1'b1;
      if (i == 2) START4 = 1'b0;
      if (DONE4) begin
        dones++;
        checks++;
        if (D4 !== 4'd5 || BOUT4 !== 1'b0) begin
          errors++;
          $display("FAIL busy_ignore_d: d=%0d bout=%b, required d=5 bout=0", D4, BOUT4);
        end
      end
      tick;
    end
    checks++;
    if (dones != 1 || busy_gap) begin
      errors++;
      $display("FAIL busy_ignore: dones=%0d busy_gap=%b, required dones=1 busy_gap=0", dones, busy_gap);
    end
  endtask

  task automatic test_reset_mid_run;
    int dones;
    logic [3:0] d;
    logic bo;
    int lat;
    bit to;
    dones = 0;
    A4 = 4'd12; B4 = 4'd4; START4 = 1'b1;
    tick;
    START4 = 1'b0;
    tick;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    checks++;
    if (BUSY4 !== 1'b0 || DONE4 !== 1'b0 || D4 !== 4'd0 || BOUT4 !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: busy=%b done=%b d=%0d bout=%b, required 0 0 0 0", BUSY4, DONE4, D4, BOUT4);
    end
    for (int i = 0; i < 8; i++) begin
      if (DONE4 || D4 !== 4'd0) dones++;
      tick;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL rst_no_done: bad cycles=%0d, required 0", dones);
    end
    op4(4'd12, 4'd4, d, bo, lat, to);
    checks++;
    if (to || lat != 4 || d !== 4'd8 || bo !== 1'b0) begin
      errors++;
      $display("FAIL rst_restart: to=%b lat=%0d d=%0d bout=%b, required lat=4 d=8 bout=0", to, lat, d, bo);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    bit to;
    A8 = 8'd200; B8 = 8'd55; START8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done8(n, to);
      checks++;
      if (to || n != ((k == 0) ? 9 : 10) || D8 !== 8'd145 || BOUT8 !== 1'b0) begin
        errors++;
        $display("FAIL b2b[%0d]: to=%b gap=%0d d=%0d bout=%b, required gap=%0d d=145 bout=0",
                 k, to, n, D8, BOUT8, (k == 0) ? 9 : 10);
      end
    end
    START8 = 1'b0;
    tick; tick;
    checks++;
    if (BUSY8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: busy=%b, required 0", BUSY8);
    end
  endtask

  task automatic test_random;
    logic [7:0] a8, b8, d8;
    logic [3:0] a4, b4, d4;
    logic bo;
    int lat;
    bit to;
    for (int i = 0; i < 20; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      op8(a8, b8, d8, bo, lat, to);
      checks++;
      if (to || lat != 8 || d8 !== 8'((int'(a8) - int'(b8) + 256) % 256) || bo !== (a8 < b8)) begin
        errors++;
        $display("FAIL rand8 %0d-%0d: to=%b lat=%0d d=%0d bout=%b, required lat=8 d=%0d bout=%b",
                 a8, b8, to, lat, d8, bo, (int'(a8) - int'(b8) + 256) % 256, (a8 < b8));
      end
    end
    for (int i = 0; i < 12; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom);
      op4(a4, b4, d4, bo, lat, to);
      checks++;
      if (to || lat != 4 || d4 !== 4'((int'(a4) - int'(b4) + 16) % 16) || bo !== (a4 < b4)) begin
        errors++;
        $display("FAIL rand4 %0d-%0d: to=%b lat=%0d d=%0d bout=%b, required lat=4 d=%0d bout=%b",
                 a4, b4, to, lat, d4, bo, (int'(a4) - int'(b4) + 16) % 16, (a4 < b4));
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic_timing;
    test_corner_values;
    test_start_while_busy;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
